// File: rtl/pipelined_decode_pkg.sv
// Shared decode constants, control-word layout and instruction classification
// for the ID stage.
package pipelined_decode_pkg;

   localparam int WORD_DEFAULT = 64;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_ADDS = 11'b10101011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_SUBS = 11'b11101011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [9:0]  OP_SUBI = 10'b1101000100;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [5:0]  OP_B    = 6'b000101;
   localparam logic [5:0]  OP_BL   = 6'b100101;

   localparam logic [2:0] BR_UNCOND = 3'b001;
   localparam logic [2:0] BR_CBZ    = 3'b010;
   localparam logic [2:0] BR_LINK   = 3'b100;

   typedef enum logic [2:0] {
      FMT_NONE, FMT_R, FMT_I, FMT_LD, FMT_ST, FMT_CB, FMT_B, FMT_BL
   } fmt_e;

   typedef enum logic {S_EMPTY, S_FULL} dec_state_e;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic       update_sreg;
      logic [2:0] branch_op;
      logic [1:0] alu_op;
      logic [1:0] mem_to_reg;
   } ctrl_t;

   function automatic fmt_e instr_format(input logic [10:0] op);
      fmt_e f;
      f = FMT_NONE;
      if (op[10:5] == OP_B)                             f = FMT_B;
      else if (op[10:5] == OP_BL)                       f = FMT_BL;
      else if (op[10:3] == OP_CBZ)                      f = FMT_CB;
      else if (op[10:1] == OP_ADDI || op[10:1] == OP_SUBI) f = FMT_I;
      else if (op == OP_LDUR)                           f = FMT_LD;
      else if (op == OP_STUR)                           f = FMT_ST;
      else if (op == OP_ADD || op == OP_ADDS || op == OP_SUB || op == OP_SUBS ||
               op == OP_AND || op == OP_ORR)            f = FMT_R;
      return f;
   endfunction

   function automatic ctrl_t control_decode(input fmt_e f, input logic [10:0] op);
      ctrl_t c;
      c = '0;
      case (f)
         FMT_R: begin
            c.reg_write   = 1'b1;
            c.alu_op      = 2'b10;
            c.update_sreg = (op == OP_ADDS) || (op == OP_SUBS);
         end
         FMT_I: begin
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
            c.alu_op    = 2'b11;
         end
         FMT_LD: begin
            c.mem_read   = 1'b1;
            c.alu_src    = 1'b1;
            c.reg_write  = 1'b1;
            c.mem_to_reg = 2'b01;
         end
         FMT_ST: begin
            c.mem_write = 1'b1;
            c.alu_src   = 1'b1;
         end
         FMT_CB: begin
            c.branch_op = BR_CBZ;
            c.alu_op    = 2'b01;
         end
         FMT_B:  c.branch_op = BR_UNCOND;
         // Link writes PC+4, selected through the third mem_to_reg source.
         FMT_BL: begin
            c.branch_op  = BR_LINK;
            c.reg_write  = 1'b1;
            c.mem_to_reg = 2'b10;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipelined_decode_regfile_bypass.sv
// Register file with two combinational read ports, hard-wired zero register and
// same-cycle write-through from the write-back port.
module regfile_bypass
   import pipelined_decode_pkg::*;
#(
   parameter int WORD      = WORD_DEFAULT,
   parameter int REG_COUNT = 32,
   parameter int ZERO_REG  = 31,
   parameter int RA        = $clog2(REG_COUNT)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [RA-1:0]   rd_idx1,
   input  logic [RA-1:0]   rd_idx2,
   input  logic            wb_en,
   input  logic [RA-1:0]   wb_reg,
   input  logic [WORD-1:0] wb_data,
   output logic [WORD-1:0] rd_data1,
   output logic [WORD-1:0] rd_data2
);
   localparam logic [RA-1:0] ZERO_IDX = RA'(ZERO_REG);

   logic [WORD-1:0] regs [REG_COUNT];
   logic            wr_ok;

   assign wr_ok = wb_en && (wb_reg != ZERO_IDX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wb_reg] <= wb_data;
      end
   end

   assign rd_data1 = (rd_idx1 == ZERO_IDX)             ? '0      :
                     (wr_ok && (wb_reg == rd_idx1))    ? wb_data : regs[rd_idx1];
   assign rd_data2 = (rd_idx2 == ZERO_IDX)             ? '0      :
                     (wr_ok && (wb_reg == rd_idx2))    ? wb_data : regs[rd_idx2];

endmodule

// File: rtl/pipelined_decode.sv
// ID stage: decode + operand read into a single ID/EX register, 1-cycle latency.
// Accepts only when the register is free or draining; one-cycle bubble on load-use.
module pipelined_decode
   import pipelined_decode_pkg::*;
#(
   parameter int WORD      = WORD_DEFAULT,
   parameter int REG_COUNT = 32,
   parameter int ZERO_REG  = 31,
   parameter int LINK_REG  = 30,
   localparam int RA       = $clog2(REG_COUNT)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instruction,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [RA-1:0]   wb_reg,
   input  logic [WORD-1:0] wb_data,
   input  logic            ex_ready,
   output logic            out_valid,
   output logic [10:0]     out_opcode,
   output logic [WORD-1:0] out_read_data1,
   output logic [WORD-1:0] out_read_data2,
   output logic [WORD-1:0] out_imm,
   output logic [RA-1:0]   out_write_reg,
   output logic [11:0]     out_ctrl,
   output logic [31:0]     stall_count
);
   localparam logic [RA-1:0] ZERO_IDX = RA'(ZERO_REG);
   localparam logic [RA-1:0] LINK_IDX = RA'(LINK_REG);

   dec_state_e      state_q, state_d;
   ctrl_t           ctrl, out_ctrl_q;
   fmt_e            fmt;
   logic [10:0]     opcode;
   logic [RA-1:0]   rn, rm, rd, sel2, wr_reg, load_rd;
   logic [WORD-1:0] imm, rd_data1, rd_data2;
   logic            hazard, accept, handoff, load_pend;

   assign opcode = instruction[31:21];
   assign rn     = RA'(instruction[9:5]);
   assign rm     = RA'(instruction[20:16]);
   assign rd     = RA'(instruction[4:0]);
   assign fmt    = instr_format(opcode);
   assign ctrl   = control_decode(fmt, opcode);
   // Stores and CBZ read their data/test register from the rd field.
   assign sel2   = (fmt == FMT_ST || fmt == FMT_CB) ? rd : rm;
   assign wr_reg = (fmt == FMT_BL) ? LINK_IDX : rd;

   always_comb begin
      imm = '0;
      case (fmt)
         FMT_I:          imm = {{(WORD-12){instruction[21]}}, instruction[21:10]};
         FMT_LD, FMT_ST: imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
         FMT_CB:         imm = {{(WORD-19){instruction[23]}}, instruction[23:5]};
         FMT_B, FMT_BL:  imm = {{(WORD-26){instruction[25]}}, instruction[25:0]};
         default:        imm = '0;
      endcase
   end

   regfile_bypass #(
      .WORD(WORD), .REG_COUNT(REG_COUNT), .ZERO_REG(ZERO_REG), .RA(RA)
   ) u_regfile (
      .clk(clk), .reset(reset),
      .rd_idx1(rn), .rd_idx2(sel2),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
      .rd_data1(rd_data1), .rd_data2(rd_data2)
   );

   assign hazard    = load_pend && (load_rd != ZERO_IDX) &&
                      ((load_rd == rn) || (load_rd == sel2));
   assign out_valid = (state_q == S_FULL);
   assign in_ready  = (!out_valid || ex_ready) && !hazard && !flush;
   assign accept    = in_valid && in_ready;
   assign handoff   = out_valid && ex_ready;
   assign out_ctrl  = out_ctrl_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush)        state_d = S_EMPTY;
      else if (accept)  state_d = S_FULL;
      else if (handoff) state_d = S_EMPTY;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_opcode     <= '0;
         out_read_data1 <= '0;
         out_read_data2 <= '0;
         out_imm        <= '0;
         out_write_reg  <= '0;
         out_ctrl_q     <= '0;
      end else if (accept) begin
         out_opcode     <= opcode;
         out_read_data1 <= rd_data1;
         out_read_data2 <= rd_data2;
         out_imm        <= imm;
         out_write_reg  <= wr_reg;
         out_ctrl_q     <= ctrl;
      end
   end

   // Remember a load for exactly one cycle after it leaves for execute.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_pend <= 1'b0;
         load_rd   <= '0;
      end else begin
         load_pend <= !flush && handoff && out_ctrl_q.mem_read;
         if (handoff && out_ctrl_q.mem_read) load_rd <= out_write_reg;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_count <= '0;
      else if (hazard && in_valid && (stall_count != 32'hFFFF_FFFF))
         stall_count <= stall_count + 32'd1;
   end

endmodule

// File: tb/tb_pipelined_decode.sv
// Directed bench for pipelined_decode with hand-computed expectations.
module tb_pipelined_decode;
   localparam int WORD = 64;
   localparam int RA   = 5;

   localparam logic [10:0] T_ADD  = 11'b10001011000;
   localparam logic [10:0] T_LDUR = 11'b11111000010;
   localparam logic [10:0] T_STUR = 11'b11111000000;
   localparam logic [5:0]  T_BL   = 6'b100101;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            in_valid, in_ready, flush, wb_en, ex_ready, out_valid;
   logic [31:0]     instruction;
   logic [RA-1:0]   wb_reg, out_write_reg;
   logic [WORD-1:0] wb_data, out_read_data1, out_read_data2, out_imm;
   logic [10:0]     out_opcode;
   logic [11:0]     out_ctrl;
   logic [31:0]     stall_count;

   int tests_run    = 0;
   int tests_failed = 0;

   pipelined_decode #(.WORD(WORD), .REG_COUNT(32), .ZERO_REG(31), .LINK_REG(30)) dut (
      .clk(clk), .reset(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
      .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
      .ex_ready(ex_ready), .out_valid(out_valid), .out_opcode(out_opcode),
      .out_read_data1(out_read_data1), .out_read_data2(out_read_data2),
      .out_imm(out_imm), .out_write_reg(out_write_reg), .out_ctrl(out_ctrl),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                         input logic [4:0] rn, input logic [4:0] rd);
      return {op, rm, 6'b000000, rn, rd};
   endfunction

   function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm9,
                                         input logic [4:0] rn, input logic [4:0] rt);
      return {op, imm9, 2'b00, rn, rt};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_write(input logic [4:0] r, input logic [63:0] d);
      wb_en = 1'b1; wb_reg = r; wb_data = d;
      tick();
      wb_en = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      ex_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      in_valid = 1'b0; instruction = '0; flush = 1'b0;
      wb_en = 1'b0; wb_reg = '0; wb_data = '0; ex_ready = 1'b1;
      tick(); tick();
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
      tests_run++; if (stall_count !== 32'd0) begin tests_failed++; $display("FAIL rst_stall: got %0d expected 0", stall_count); end
      tests_run++; if (out_ctrl !== 12'h000 || out_write_reg !== 5'd0) begin tests_failed++; $display("FAIL rst_outs: got ctrl %h wr %0d expected 0/0", out_ctrl, out_write_reg); end
      reset_n = 1'b1;
      instruction = enc_r(T_ADD, 5'd0, 5'd0, 5'd7);
      in_valid = 1'b1;
      #1;
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_first_ready: got %b expected 1", in_ready); end
      tick();
      tests_run++; if (out_valid !== 1'b1 || out_write_reg !== 5'd7) begin tests_failed++; $display("FAIL rst_first_accept: got v=%b wr=%0d expected v=1 wr=7", out_valid, out_write_reg); end
      drain();
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL handoff_empty: got %b expected 0", out_valid); end
   endtask

   task automatic test_add();
      wb_write(5'd2, 64'd5);
      wb_write(5'd3, 64'd7);
      instruction = enc_r(T_ADD, 5'd3, 5'd2, 5'd1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL add_valid: got %b expected 1", out_valid); end
      tests_run++; if (out_read_data1 !== 64'd5 || out_read_data2 !== 64'd7) begin tests_failed++; $display("FAIL add_operands: got %0h/%0h expected 5/7", out_read_data1, out_read_data2); end
      tests_run++; if (out_opcode !== 11'h458 || out_ctrl !== 12'h108 || out_write_reg !== 5'd1) begin tests_failed++; $display("FAIL add_decode: got op %h ctrl %h wr %0d expected 458/108/1", out_opcode, out_ctrl, out_write_reg); end
      drain();
   endtask

   task automatic test_load_use();
      instruction = enc_d(T_LDUR, 9'd0, 5'd0, 5'd4);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tests_run++; if (out_ctrl !== 12'hB01 || out_write_reg !== 5'd4) begin tests_failed++; $display("FAIL ldur_decode: got ctrl %h wr %0d expected B01/4", out_ctrl, out_write_reg); end
      tick();
      instruction = enc_r(T_ADD, 5'd4, 5'd4, 5'd5);
      in_valid = 1'b1;
      #1;
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL loaduse_stall: got in_ready %b expected 0", in_ready); end
      tick();
      tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL loaduse_one_cycle: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
      tests_run++; if (stall_count !== 32'd1) begin tests_failed++; $display("FAIL loaduse_count: got %0d expected 1", stall_count); end
      tick();
      tests_run++; if (out_valid !== 1'b1 || out_write_reg !== 5'd5) begin tests_failed++; $display("FAIL loaduse_issue: got v=%b wr=%0d expected v=1 wr=5", out_valid, out_write_reg); end
      drain();
      // A load into the zero register never stalls its consumer.
      instruction = enc_d(T_LDUR, 9'd0, 5'd0, 5'd31);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      instruction = enc_r(T_ADD, 5'd31, 5'd31, 5'd5);
      in_valid = 1'b1;
      #1;
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL zero_load_nostall: got in_ready %b expected 1", in_ready); end
      tick();
      drain();
      tests_run++; if (stall_count !== 32'd1) begin tests_failed++; $display("FAIL zero_load_count: got %0d expected 1", stall_count); end
   endtask

   task automatic test_store();
      wb_write(5'd6, 64'h66);
      instruction = enc_d(T_STUR, 9'h1FF, 5'd2, 5'd6);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tests_run++; if (out_read_data1 !== 64'd5 || out_read_data2 !== 64'h66) begin tests_failed++; $display("FAIL stur_operands: got %0h/%0h expected 5/66", out_read_data1, out_read_data2); end
      tests_run++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF || out_ctrl !== 12'h600) begin tests_failed++; $display("FAIL stur_imm_ctrl: got imm %h ctrl %h expected all-ones/600", out_imm, out_ctrl); end
      drain();
   endtask

   task automatic test_bypass();
      instruction = enc_r(T_ADD, 5'd3, 5'd9, 5'd1);
      in_valid = 1'b1;
      wb_en = 1'b1; wb_reg = 5'd9; wb_data = 64'hDEAD;
      tick();
      wb_en = 1'b0; in_valid = 1'b0;
      tests_run++; if (out_read_data1 !== 64'hDEAD || out_read_data2 !== 64'd7) begin tests_failed++; $display("FAIL bypass: got %0h/%0h expected dead/7", out_read_data1, out_read_data2); end
      drain();
      instruction = enc_r(T_ADD, 5'd9, 5'd9, 5'd1);
      in_valid = 1'b1;
      tick();
      tests_run++; if (out_read_data2 !== 64'hDEAD) begin tests_failed++; $display("FAIL bypass_stored: got %0h expected dead", out_read_data2); end
      drain();
   endtask

   task automatic test_zero_reg();
      wb_write(5'd31, 64'h55);
      instruction = enc_r(T_ADD, 5'd31, 5'd31, 5'd1);
      in_valid = 1'b1;
      wb_en = 1'b1; wb_reg = 5'd31; wb_data = 64'h77;
      tick();
      wb_en = 1'b0; in_valid = 1'b0;
      tests_run++; if (out_read_data1 !== 64'd0) begin tests_failed++; $display("FAIL zero_read1: got %0h expected 0", out_read_data1); end
      tests_run++; if (out_read_data2 !== 64'd0) begin tests_failed++; $display("FAIL zero_read2: got %0h expected 0", out_read_data2); end
      drain();
   endtask

   task automatic test_stall_flush();
      instruction = enc_r(T_ADD, 5'd3, 5'd2, 5'd1);
      in_valid = 1'b1;
      tick();
      ex_ready = 1'b0;
      instruction = enc_r(T_ADD, 5'd2, 5'd2, 5'd6);
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_ready[%0d]: got %b expected 0", i, in_ready); end
         tests_run++; if (out_valid !== 1'b1 || out_read_data1 !== 64'd5 || out_read_data2 !== 64'd7 || out_write_reg !== 5'd1) begin tests_failed++; $display("FAIL hold_stable[%0d]: got v=%b %0h/%0h wr=%0d expected 1 5/7 wr=1", i, out_valid, out_read_data1, out_read_data2, out_write_reg); end
         tick();
      end
      flush = 1'b1;
      #1;
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
      tick();
      flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_empty: got %b expected 0", out_valid); end
      // Flush coinciding with a load hand-off must not arm the load-use check.
      instruction = enc_d(T_LDUR, 9'd0, 5'd0, 5'd4);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      instruction = enc_r(T_ADD, 5'd4, 5'd4, 5'd5);
      in_valid = 1'b1;
      #1;
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_clears_load: got in_ready %b expected 1", in_ready); end
      tick();
      tests_run++; if (out_valid !== 1'b1 || stall_count !== 32'd1) begin tests_failed++; $display("FAIL flush_after_issue: got v=%b stalls=%0d expected 1/1", out_valid, stall_count); end
      drain();
   endtask

   task automatic test_bl_reset();
      instruction = {T_BL, 26'h3FF_FFFF};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0; ex_ready = 1'b0;
      tests_run++; if (out_write_reg !== 5'd30) begin tests_failed++; $display("FAIL bl_link: got %0d expected 30", out_write_reg); end
      tests_run++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF || out_ctrl !== 12'h142) begin tests_failed++; $display("FAIL bl_imm_ctrl: got imm %h ctrl %h expected all-ones/142", out_imm, out_ctrl); end
      tick();
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bl_held: got %b expected 1", out_valid); end
      #2;
      reset_n = 1'b0;
      wb_en = 1'b1; wb_reg = 5'd2; wb_data = 64'h123;
      #1;
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL async_reset_valid: got %b expected 0", out_valid); end
      tests_run++; if (out_write_reg !== 5'd0 || out_ctrl !== 12'h000 || out_imm !== 64'd0) begin tests_failed++; $display("FAIL async_reset_outs: got wr %0d ctrl %h imm %h expected zeros", out_write_reg, out_ctrl, out_imm); end
      tick();
      wb_en = 1'b0;
      reset_n = 1'b1;
      ex_ready = 1'b1;
      instruction = enc_r(T_ADD, 5'd3, 5'd2, 5'd1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL post_reset_accept: got %b expected 1", out_valid); end
      tests_run++; if (out_read_data1 !== 64'd0 || out_read_data2 !== 64'd0) begin tests_failed++; $display("FAIL post_reset_regs: got %0h/%0h expected 0/0", out_read_data1, out_read_data2); end
      drain();
   endtask

   initial begin
      test_reset();
      test_add();
      test_load_use();
      test_store();
      test_bypass();
      test_zero_reg();
      test_stall_flush();
      test_bl_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pipelined_decode.md
PIPELINED_DECODE -- requirements
Module: pipelined_decode

Interface
REQ-001 SHALL have parameter WORD, default 64: data-path width in bits.
REQ-002 SHALL have parameter REG_COUNT, default 32: number of architectural registers; address width RA = clog2(REG_COUNT).
REQ-003 SHALL have parameter ZERO_REG, default 31: register index that reads as 0 and ignores writes.
REQ-004 SHALL have parameter LINK_REG, default 30: write destination for link-type (BL) instructions.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1: instruction is presented.
REQ-008 SHALL have port in_ready, output, 1: instruction accepted this cycle if in_valid.
REQ-009 SHALL have port instruction, input, 32: instruction word.
REQ-010 SHALL have port flush, input, 1: discard in-flight decode state.
REQ-011 SHALL have port wb_en, input, 1: write-back enable.
REQ-012 SHALL have port wb_reg, input, RA: write-back register index.
REQ-013 SHALL have port wb_data, input, WORD: write-back data.
REQ-014 SHALL have port ex_ready, input, 1: execute stage consumes the output this cycle.
REQ-015 SHALL have port out_valid, output, 1: ID/EX register holds a decoded instruction.
REQ-016 SHALL have port out_opcode, output, 11: captured opcode field.
REQ-017 SHALL have ports out_read_data1 and out_read_data2, output, WORD each: operands as sampled at accept time.
REQ-018 SHALL have port out_imm, output, WORD: sign-extended immediate.
REQ-019 SHALL have port out_write_reg, output, RA: destination register (rd, or LINK_REG for link instructions).
REQ-020 SHALL have port out_ctrl, output, 12: packed {mem_read, mem_write, alu_src, reg_write, update_sreg, branch_op[2:0], alu_op[1:0], mem_to_reg[1:0]}.
REQ-021 SHALL have port stall_count, output, 32: saturating count of cycles lost to load-use stalls.

Function
REQ-022 SHALL hold the ID/EX register in one of two states: EMPTY (out_valid=0) or FULL (out_valid=1).
REQ-023 SHALL drive in_ready = (!out_valid | ex_ready) & !hazard & !flush.
REQ-024 SHALL, on an accept (in_valid & in_ready), capture all decoded outputs at the next edge; latency is 1 cycle.
REQ-025 SHALL, on an ex_ready handshake with no accept, transition FULL->EMPTY.
REQ-026 SHALL, when FULL and !ex_ready, hold every out_* output stable.
REQ-027 SHALL select the second read index as rm for R-format and rd for store/CBZ formats, per control decode.
REQ-028 SHALL return 0 for any read of ZERO_REG and SHALL ignore writes to ZERO_REG.
REQ-029 SHALL write wb_data into wb_reg at the edge when wb_en=1.
REQ-030 SHALL bypass wb_data to a read port in the same cycle when wb_en=1 and wb_reg equals that port's index (write-through).
REQ-031 SHALL set load_pend=1 and load_rd=out_write_reg at the edge where a FULL entry with mem_read=1 is handed off, and SHALL clear load_pend at the following edge.
REQ-032 SHALL assert hazard when load_pend=1, load_rd!=ZERO_REG and load_rd matches rn or the selected second read index; this holds in_ready low for exactly one cycle.
REQ-033 SHALL increment stall_count once per cycle where hazard & in_valid, saturating at 0xFFFFFFFF.
REQ-034 SHALL, on flush, force EMPTY and clear load_pend at the next edge, and SHALL NOT accept an instruction that cycle; register-file writes still proceed.
REQ-035 SHALL give flush priority over accept and hand-off when asserted simultaneously.

Reset
REQ-036 SHALL, while reset=0, force out_valid=0, load_pend=0, stall_count=0, all out_* data/control to 0, and all registers to 0.
REQ-037 SHALL discard any in-flight entry and pending write when reset asserts mid-operation; the first accept is possible in the first cycle after release.

Structure
REQ-038 SHALL take WORD defaults, the out_ctrl field layout and the opcode constants from the shared constants.vh.
REQ-039 SHALL implement the register array with bypass and zero-register logic as sub-module regfile_bypass; parse, control and sign-extension logic SHALL reuse the existing instr_parse, control and sign_extender.

Verification
REQ-040 SHALL test: reset release, ADD X1,X2,X3 with X2=5, X3=7 preset -> out_valid next cycle, out_read_data1=5, out_read_data2=7.
REQ-041 SHALL test: LDUR X4 then ADD X5,X4,X4 back-to-back -> in_ready low for 1 cycle, stall_count=1, ADD issued next.
REQ-042 SHALL test: wb_en=1, wb_reg=9, wb_data=0xDEAD in the accept cycle of a read of X9 -> out_read_data1=0xDEAD.
REQ-043 SHALL test: write 0x55 to X31, then read X31 -> 0.
REQ-044 SHALL test: ex_ready=0 for 3 cycles while FULL -> outputs stable and in_ready=0; flush during the stall -> out_valid=0 next cycle.
REQ-045 SHALL test: BL -> out_write_reg=30; reset asserted while FULL -> out_valid=0 immediately.
